// File: rtl/sdram_req_sched_pkg.sv
// sdram_sched_pkg: shared types and helpers for the SDRAM request scheduler.
//   state_e  : scheduler FSM states (IDLE, XFER, GAP)
//   BE_ALL   : byte-enable value driven on every SDRAM access
//   next_rr  : round-robin successor of a requester index, never landing on
//              the fixed-priority (PCM) requester
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] BE_ALL = 2'b11;

  function automatic int next_rr(input int idx, input int nreq, input int pcm_idx);
    int n;
    n = (idx + 1) % nreq;
    if (n == pcm_idx) n = (n + 1) % nreq;
    return n;
  endfunction

endpackage

// File: rtl/sdram_req_sched_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   valid_i : request vector
//   ptr_i   : index with highest priority this round
//   skip_i  : index excluded from round-robin (served elsewhere)
//   win_o   : one-hot winner, 0 when nothing eligible
//   any_o   : some eligible request exists
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic [PW-1:0]   skip_i,
  output logic [NREQ-1:0] win_o,
  output logic            any_o
);

  always_comb begin
    int idx;
    win_o = '0;
    any_o = 1'b0;
    idx   = 0;
    // Walk indices starting at ptr_i, wrapping; first eligible one wins.
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!any_o && valid_i[idx] && (idx != int'(skip_i))) begin
        win_o[idx] = 1'b1;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_req_sched.sv
// sdram_req_sched: grants the single SDRAM word port to one of NREQ clients.
// The PCM requester has absolute priority; the rest share round-robin.
// Each grant is capped at MAX_BURST words and followed by one GAP cycle so
// command strobes always drop between owners.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   new_frame         : frame-start pulse, restarts round-robin order
//   req_valid/write/last, req_addr, req_wrdata : packed per-requester words
//   req_ac, req_rddata: per-word acknowledge / read data back to owner
//   grant             : one-hot current owner (0 when idle)
//   ar_*              : SDRAM word port
//   busy              : transfer in progress
//
// Optional build macro SCHED_STATS_EN adds stat_grants (per-requester
// saturating grant counters) and stat_pcm_wait_max (longest PCM wait in
// cycles); both cleared on reset or new_frame.
module sdram_req_sched
  import sdram_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int PCM_IDX   = 0,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_frame,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wrdata,
  output logic [NREQ-1:0]          req_ac,
  output logic [DATA_W-1:0]        req_rddata,
  output logic [NREQ-1:0]          grant,
  output logic [ADDR_W-1:0]        ar_addr,
  output logic [1:0]               ar_be,
  output logic                     ar_read,
  output logic                     ar_write,
  output logic [DATA_W-1:0]        ar_wrdata,
  input  logic                     ar_ac,
  input  logic [DATA_W-1:0]        ar_rddata,
  output logic                     busy
`ifdef SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]       stat_grants,
  output logic [15:0]              stat_pcm_wait_max
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [PW-1:0] PCM_P   = PW'(PCM_IDX);
  localparam logic [PW-1:0] PTR_RST = PW'((PCM_IDX + 1) % NREQ);

  state_e            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [PW-1:0]     gidx_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [CW-1:0]     word_cnt_q;

  logic [NREQ-1:0]   rr_win;
  logic              rr_any;
  logic [NREQ-1:0]   sel_oh;
  logic [PW-1:0]     sel_idx;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .skip_i  (PCM_P),
    .win_o   (rr_win),
    .any_o   (rr_any)
  );

  // PCM overrides the round-robin winner unconditionally.
  always_comb begin
    sel_oh  = rr_win;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (rr_win[i]) sel_idx = PW'(i);
    if (req_valid[PCM_IDX]) begin
      sel_oh          = '0;
      sel_oh[PCM_IDX] = 1'b1;
      sel_idx         = PCM_P;
    end
  end

  // Command path is combinational from the owner; gating with reset keeps
  // strobes and acks quiet in the reset cycle even if state is still XFER.
  logic in_xfer, g_valid, g_write, g_last, word_ack, burst_end, xfer_end;
  assign in_xfer   = (state_q == XFER) && !reset;
  assign g_valid   = req_valid[gidx_q];
  assign g_write   = req_write[gidx_q];
  assign g_last    = req_last[gidx_q];
  assign word_ack  = in_xfer && g_valid && ar_ac;
  assign burst_end = word_ack && (g_last || (word_cnt_q == CW'(MAX_BURST - 1)));
  assign xfer_end  = in_xfer && (!g_valid || burst_end);

  assign ar_read    = in_xfer && g_valid && !g_write;
  assign ar_write   = in_xfer && g_valid && g_write;
  assign ar_addr    = in_xfer ? req_addr[int'(gidx_q)*ADDR_W +: ADDR_W] : '0;
  assign ar_wrdata  = in_xfer ? req_wrdata[int'(gidx_q)*DATA_W +: DATA_W] : '0;
  assign ar_be      = BE_ALL;
  assign req_ac     = word_ack ? grant_q : '0;
  assign req_rddata = ar_rddata;
  assign grant      = grant_q;
  assign busy       = (state_q == XFER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= PTR_RST;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            state_q    <= XFER;
            grant_q    <= sel_oh;
            gidx_q     <= sel_idx;
            word_cnt_q <= '0;
          end
        end
        XFER: begin
          if (word_ack) word_cnt_q <= word_cnt_q + CW'(1);
          if (xfer_end) begin
            state_q <= GAP;
            grant_q <= '0;
            if (gidx_q != PCM_P)
              rr_ptr_q <= PW'(next_rr(int'(gidx_q), NREQ, PCM_IDX));
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Frame start restarts the rotation and beats any pointer update above.
      if (new_frame) rr_ptr_q <= PTR_RST;
    end
  end

`ifdef SCHED_STATS_EN
  logic [NREQ-1:0][15:0] grants_q;
  logic [15:0]           pcm_wait_q;
  logic [15:0]           pcm_wait_max_q;
  logic                  grant_take, pcm_owns;
  logic [15:0]           wait_inc;

  assign grant_take = (state_q == IDLE) && (|req_valid);
  assign pcm_owns   = (state_q == XFER) && (gidx_q == PCM_P);
  assign wait_inc   = (pcm_wait_q == 16'hFFFF) ? pcm_wait_q : pcm_wait_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset || new_frame) begin
      grants_q       <= '0;
      pcm_wait_q     <= '0;
      pcm_wait_max_q <= '0;
    end else begin
      if (grant_take)
        for (int i = 0; i < NREQ; i++)
          if (sel_oh[i] && grants_q[i] != 16'hFFFF) grants_q[i] <= grants_q[i] + 16'd1;
      // The granting IDLE cycle itself counts as waited.
      if (req_valid[PCM_IDX] && !pcm_owns) begin
        if (grant_take) begin
          pcm_wait_q <= '0;
          if (wait_inc > pcm_wait_max_q) pcm_wait_max_q <= wait_inc;
        end else begin
          pcm_wait_q <= wait_inc;
        end
      end else begin
        pcm_wait_q <= '0;
      end
    end
  end

  assign stat_grants       = grants_q;
  assign stat_pcm_wait_max = pcm_wait_max_q;
`endif

endmodule
